jpeg_irle_expand: RTL and testbench

JPEG_IRLE_EXPAND -- requirements
Module: jpeg_irle_expand

---
 rtl/jpeg_irle_pkg.sv | 20 ++
 rtl/irle_outreg.sv | 35 +++
 rtl/jpeg_irle_expand.sv | 142 ++++++++++++++
 tb/tb_jpeg_irle_expand.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_irle_pkg.sv
// Shared definitions for the JPEG inverse run-length expander: token layout,
// block geometry and FSM state encoding.
package jpeg_irle_pkg;
  localparam int BLOCK_LEN = 64;
  localparam int ZRL_RUN   = 15;
  localparam int LEVEL_W   = 12;
  localparam int RUN_W     = $clog2(ZRL_RUN + 1);
  localparam int RUN_LSB   = LEVEL_W;
  localparam int TOK_W     = 1 + RUN_W + LEVEL_W;
  localparam int EOB_BIT   = TOK_W - 1;
  localparam int POS_W     = $clog2(BLOCK_LEN);

  typedef enum logic [2:0] {
    READ   = 3'd0,
    ZERO   = 3'd1,
    LEVEL  = 3'd2,
    FILL   = 3'd3,
    ENDTOK = 3'd4
  } irleState_t;
endpackage

// File: rtl/irle_outreg.sv
// One-entry output holding register with valid/end/back-pressure handshake.
// free is high when the slot is empty or its contents transfer this cycle.
module irle_outreg
  import jpeg_irle_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic [LEVEL_W-1:0] pushD,
  input  logic               pushE,
  output logic               free,
  output logic [LEVEL_W-1:0] coefD,
  output logic               coefV,
  output logic               coefE,
  input  logic               coefB
);

  assign free = !coefV || !coefB;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      coefD <= '0;
      coefV <= 1'b0;
      coefE <= 1'b0;
    end else if (push) begin
      coefD <= pushD;
      coefV <= 1'b1;
      coefE <= pushE;
    end else if (coefV && !coefB) begin
      coefV <= 1'b0;
      coefE <= 1'b0;
    end
  end

endmodule

// File: rtl/jpeg_irle_expand.sv
// Expands {eob, run, level} tokens into a 64-coefficient zigzag stream.
// States: READ take token | ZERO emit run zeros | LEVEL emit latched level | FILL zero-pad to 63 | ENDTOK emit end marker
module jpeg_irle_expand
  import jpeg_irle_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic [TOK_W-1:0]   tok_d,
  input  logic               tok_v,
  input  logic               tok_e,
  output logic               tok_b,
  output logic [LEVEL_W-1:0] coef_d,
  output logic               coef_v,
  output logic               coef_e,
  input  logic               coef_b,
  output logic [POS_W-1:0]   pos,
  output logic               err
);

  irleState_t         state, stateNext;
  logic [POS_W-1:0]   posNext;
  logic [RUN_W-1:0]   zrem, zremNext;
  logic [LEVEL_W-1:0] levelQ, levelNext;
  logic               errNext, endPend, endPendNext, rdy;
  logic               outFree, push, pushE, accept, overflow, lastPos;
  logic [LEVEL_W-1:0] pushD;
  logic               tokEob;
  logic [RUN_W-1:0]   tokRun;
  logic [LEVEL_W-1:0] tokLevel;
  logic [POS_W:0]     levelPos;

  assign tokEob   = tok_d[EOB_BIT];
  assign tokRun   = tok_d[RUN_LSB +: RUN_W];
  assign tokLevel = tok_d[LEVEL_W-1:0];
  assign levelPos = {1'b0, pos} + (POS_W+1)'(tokRun);
  assign overflow = levelPos >= (POS_W+1)'(BLOCK_LEN);
  assign lastPos  = pos == POS_W'(BLOCK_LEN - 1);

  // rdy holds tok_b high until the first edge after reset release
  assign tok_b  = !(rdy && state == READ && outFree);
  assign accept = tok_v && !tok_b;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= READ;
      pos     <= '0;
      zrem    <= '0;
      levelQ  <= '0;
      err     <= 1'b0;
      endPend <= 1'b0;
      rdy     <= 1'b0;
    end else begin
      state   <= stateNext;
      pos     <= posNext;
      zrem    <= zremNext;
      levelQ  <= levelNext;
      err     <= errNext;
      endPend <= endPendNext;
      rdy     <= 1'b1;
    end
  end

  always_comb begin
    stateNext   = state;
    posNext     = pos;
    zremNext    = zrem;
    levelNext   = levelQ;
    errNext     = err;
    endPendNext = endPend;
    push        = 1'b0;
    pushD       = '0;
    pushE       = 1'b0;
    case (state)
      READ: if (accept) begin
        push    = 1'b1;
        posNext = pos + 1'b1;
        if (tok_e) begin
          if (pos == '0) begin
            push      = 1'b0;
            posNext   = pos;
            stateNext = ENDTOK;
          end else begin
            // truncated block: pad it out before the end marker
            errNext     = 1'b1;
            endPendNext = 1'b1;
            stateNext   = lastPos ? ENDTOK : FILL;
          end
        end else if (tokEob) begin
          if (!lastPos) stateNext = FILL;
        end else if (tokRun == '0) begin
          pushD = tokLevel;
        end else if (overflow) begin
          errNext = 1'b1;
          if (!lastPos) stateNext = FILL;
        end else begin
          zremNext  = tokRun - 1'b1;
          levelNext = tokLevel;
          stateNext = (tokRun == RUN_W'(1)) ? LEVEL : ZERO;
        end
      end
      ZERO: if (outFree) begin
        push     = 1'b1;
        posNext  = pos + 1'b1;
        zremNext = zrem - 1'b1;
        if (zrem == RUN_W'(1)) stateNext = LEVEL;
      end
      LEVEL: if (outFree) begin
        push      = 1'b1;
        pushD     = levelQ;
        posNext   = pos + 1'b1;
        stateNext = READ;
      end
      FILL: if (outFree) begin
        push    = 1'b1;
        posNext = pos + 1'b1;
        if (lastPos) stateNext = endPend ? ENDTOK : READ;
      end
      ENDTOK: if (outFree) begin
        push        = 1'b1;
        pushE       = 1'b1;
        posNext     = '0;
        endPendNext = 1'b0;
        stateNext   = READ;
      end
      default: stateNext = READ;
    endcase
  end

  irle_outreg uOutReg (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pushD (pushD),
    .pushE (pushE),
    .free  (outFree),
    .coefD (coef_d),
    .coefV (coef_v),
    .coefE (coef_e),
    .coefB (coef_b)
  );

endmodule

// File: tb/tb_jpeg_irle_expand.sv
// Bench for jpeg_irle_expand: directed block scenarios plus random token streams
// checked against a queue-based model of the expected coefficient stream.
module tb_jpeg_irle_expand;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [16:0] tok_d = '0;
  logic        tok_v = 1'b0;
  logic        tok_e = 1'b0;
  logic        tok_b;
  logic [11:0] coef_d;
  logic        coef_v;
  logic        coef_e;
  logic        coef_b = 1'b0;
  logic [5:0]  pos;
  logic        err;

  int nComp = 0;
  int nFail = 0;
  int bMode = 0;  // 0 always ready, 1 random stalls, 2 hold stalled
  logic [12:0] obsQ[$];
  logic [12:0] expQ[$];
  int   mPos = 0;
  logic mErr = 1'b0;
  logic prevStall = 1'b0;
  logic [12:0] prevOut = '0;

  always #5 clock = ~clock;

  jpeg_irle_expand dut (
    .clock  (clock),
    .reset  (reset),
    .tok_d  (tok_d),
    .tok_v  (tok_v),
    .tok_e  (tok_e),
    .tok_b  (tok_b),
    .coef_d (coef_d),
    .coef_v (coef_v),
    .coef_e (coef_e),
    .coef_b (coef_b),
    .pos    (pos),
    .err    (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nComp++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clock) begin
    #1;
    case (bMode)
      0:       coef_b = 1'b0;
      1:       coef_b = ($urandom_range(0, 3) == 0);
      default: coef_b = 1'b1;
    endcase
  end

  // Transfers are recorded half a cycle before the edge that completes them.
  always @(negedge clock) begin
    if (!reset) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) check("stall_hold", {coef_v, coef_e, coef_d}, {1'b1, prevOut});
      if (coef_v && coef_b) check("stall_tokb", tok_b, 1);
      if (coef_v && !coef_b) obsQ.push_back({coef_e, coef_d});
      prevStall = coef_v && coef_b;
      prevOut   = {coef_e, coef_d};
    end
  end

  function automatic logic [16:0] tk(input logic eob, input int run, input int lvl);
    return {eob, 4'(run), 12'(lvl)};
  endfunction

  task automatic zeros(input int n);
    for (int i = 0; i < n; i++) expQ.push_back(13'd0);
  endtask

  task automatic modelTok(input logic [16:0] d, input logic e);
    int run;
    logic [11:0] lvl;
    run = int'(d[15:12]);
    lvl = d[11:0];
    if (e) begin
      if (mPos != 0) begin
        mErr = 1'b1;
        zeros(64 - mPos);
      end
      expQ.push_back({1'b1, 12'd0});
      mPos = 0;
    end else if (d[16]) begin
      zeros(64 - mPos);
      mPos = 0;
    end else if (mPos + run + 1 > 64) begin
      zeros(64 - mPos);
      mErr = 1'b1;
      mPos = 0;
    end else begin
      zeros(run);
      expQ.push_back({1'b0, lvl});
      mPos = (mPos + run + 1) % 64;
    end
  endtask

  task automatic sendTok(input logic [16:0] d, input logic e);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    tok_d = d;
    tok_e = e;
    tok_v = 1'b1;
    while (!done && n < 500) begin
      @(negedge clock);
      done = !tok_b;
      @(posedge clock);
      #1;
      n++;
    end
    tok_v = 1'b0;
    tok_e = 1'b0;
    check("send_accepted", done, 1);
    modelTok(d, e);
  endtask

  task automatic drainCheck(input string tag);
    int n;
    n = 0;
    while (obsQ.size() < expQ.size() && n < 3000) begin
      @(posedge clock);
      #1;
      n++;
    end
    repeat (4) @(posedge clock);
    #1;
    check({tag, "_count"}, obsQ.size(), expQ.size());
    for (int i = 0; i < obsQ.size() && i < expQ.size(); i++)
      check($sformatf("%s_coef%0d", tag, i), obsQ[i], expQ[i]);
    check({tag, "_pos"}, pos, mPos);
    check({tag, "_err"}, err, mErr);
    obsQ.delete();
    expQ.delete();
  endtask

  task automatic doReset(input string tag);
    reset = 1'b0;
    tok_v = 1'b0;
    tok_e = 1'b0;
    #1;
    check({tag, "_coefv"}, coef_v, 0);
    check({tag, "_coefe"}, coef_e, 0);
    check({tag, "_coefd"}, coef_d, 0);
    check({tag, "_tokb"}, tok_b, 1);
    check({tag, "_pos"}, pos, 0);
    check({tag, "_err"}, err, 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check({tag, "_tokb_held"}, tok_b, 1);
    @(posedge clock);
    #1;
    check({tag, "_tokb_fall"}, tok_b, 0);
    obsQ.delete();
    expQ.delete();
    mPos = 0;
    mErr = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int r;
    bMode = 0;
    repeat (2) @(posedge clock);
    #1;
    doReset("rst_init");

    sendTok(tk(0, 0, 5), 0);
    sendTok(tk(0, 2, -3), 0);
    sendTok(tk(1, 0, 0), 0);
    drainCheck("basic");

    sendTok(tk(1, 0, 0), 0);
    drainCheck("eob_pos0");
    sendTok(tk(0, 0, 0), 1);
    drainCheck("end_tok");

    sendTok(tk(0, 15, 0), 0);
    sendTok(tk(0, 0, 7), 0);
    sendTok(tk(1, 0, 0), 0);
    drainCheck("zrl");

    for (int i = 0; i < 3; i++) sendTok(tk(0, 15, 1), 0);
    sendTok(tk(0, 11, 1), 0);
    drainCheck("to_pos60");
    sendTok(tk(0, 10, 9), 0);
    drainCheck("overflow");
    doReset("rst_ovf");

    sendTok(tk(0, 0, 3), 0);
    sendTok(tk(0, 0, 0), 1);
    drainCheck("trunc_end");
    doReset("rst_trunc");

    sendTok(tk(0, 15, 4), 0);
    repeat (3) @(posedge clock);
    #1;
    bMode = 2;
    repeat (5) @(posedge clock);
    #1;
    bMode = 0;
    sendTok(tk(1, 0, 0), 0);
    drainCheck("stall");

    sendTok(tk(0, 15, 1), 0);
    sendTok(tk(0, 15, 1), 0);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (pos != 6'd30 && n < 100);
    check("mid_reached_pos", pos, 30);
    doReset("rst_mid");
    sendTok(tk(0, 0, 1), 0);
    sendTok(tk(1, 0, 0), 0);
    drainCheck("after_rst");

    bMode = 1;
    for (int t = 0; t < 300; t++) begin
      r = $urandom_range(0, 15);
      if (r == 0)      sendTok(tk(0, 0, 0), 1);
      else if (r < 3)  sendTok(tk(1, $urandom_range(0, 15), $urandom_range(0, 4095)), 0);
      else if (r < 8)  sendTok(tk(0, $urandom_range(0, 3), $urandom_range(0, 4095)), 0);
      else             sendTok(tk(0, $urandom_range(0, 15), $urandom_range(0, 4095)), 0);
      if (t % 50 == 49) drainCheck("rand");
    end
    bMode = 0;
    drainCheck("rand_final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nFail);
    $finish;
  end

endmodule
